// File: rtl/mem_req_pkg.sv
// Shared definitions for the memory request controller slice.
// Contents: default address/data widths, default clear word and the
// controller state encoding (IDLE / CLEAR / DONE).
package mem_req_pkg;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 32;
    localparam logic [DEF_DATA_W-1:0] DEF_CLEAR_VALUE = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Request/response bus between a requester and mem_req_ctrl.
// Request channel : req_valid, req_ready, req_we, req_addr, req_wdata
// Response channel: rsp_valid, rsp_ready, rsp_rdata
// master = requester side, slave = controller side.
interface mem_req_ctrl_if
    import mem_req_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/mem_rsp_fifo.sv
// Synchronous response FIFO holding read data returned by the RAM.
// Ports: clk, rst (sync, active-high), push/push_data (write side),
// pop (consumer takes head), head_valid/head_data (FIFO head, data
// forced to zero when empty), count (current occupancy).
// Push and pop in the same cycle are accepted even when full.
module mem_rsp_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic                         head_valid,
    output logic [DATA_W-1:0]            head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] store [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              empty;
    logic              full;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        empty      = (count == '0);
        full       = (count == CNT_W'(DEPTH));
        do_pop     = pop && !empty;
        // A full FIFO can still take a push when the head leaves this cycle.
        do_push    = push && (!full || do_pop);
        head_valid = !empty;
        head_data  = empty ? '0 : store[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    overflow_check : assert property (@(posedge clk) disable iff (rst)
        !(push && full && !pop));

endmodule

// File: rtl/mem_req_ctrl.sv
// Request controller in front of a single-port synchronous RAM with a
// 1-cycle registered read. Accepts read/write requests, returns read
// data through a credit-controlled response FIFO and contains a clear
// engine that writes CLEAR_VALUE to every word.
// Ports: clk, rst (sync, active-high); bus (mem_req_ctrl_if.slave:
// request and response handshakes); clear_start / clear_busy /
// clear_done (clear engine control/status); mem_addr, mem_wdata,
// mem_we (to RAM), mem_rdata (from RAM, valid 1 cycle after issue).
module mem_req_ctrl
    import mem_req_pkg::*;
#(
    parameter int                ADDR_W         = DEF_ADDR_W,
    parameter int                DATA_W         = DEF_DATA_W,
    parameter int                RSP_DEPTH      = 2,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = DATA_W'(DEF_CLEAR_VALUE),
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    mem_req_ctrl_if.slave     bus,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam int              CNT_W    = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W + 1)'(DEPTH - 1);

    ctrl_state_t       state;
    logic [ADDR_W:0]   ptr;
    logic              boot_clear;
    logic              inflight;
    logic [CNT_W-1:0]  rsp_count;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_pop;
    logic [CNT_W:0]    occupancy;
    logic              credit_ok;
    logic              ready;
    logic              accept;
    logic              accept_rd;

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;

    // Reads need a guaranteed FIFO slot: entries held, plus the read
    // whose data is on mem_rdata now, minus the entry leaving this cycle.
    // boot_clear holds off requests until the reset-triggered sweep starts.
    always_comb begin
        rsp_pop   = rsp_valid && bus.rsp_ready;
        occupancy = {1'b0, rsp_count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(rsp_pop);
        credit_ok = occupancy < (CNT_W + 1)'(RSP_DEPTH);
        ready     = !rst && (state == IDLE) && !boot_clear && (bus.req_we || credit_ok);
        accept    = bus.req_valid && ready;
        accept_rd = accept && !bus.req_we;

        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = ptr[ADDR_W-1:0];
            mem_wdata = CLEAR_VALUE;
        end else if (accept) begin
            mem_we    = bus.req_we;
            mem_addr  = bus.req_addr;
            mem_wdata = bus.req_we ? bus.req_wdata : '0;
        end
    end

    // ptr carries one extra bit so the terminal count is exact and never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            boot_clear <= CLEAR_ON_RESET;
            inflight   <= 1'b0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            inflight   <= accept_rd;
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (boot_clear || clear_start) begin
                        state      <= CLEAR;
                        ptr        <= '0;
                        boot_clear <= 1'b0;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    ptr <= ptr + (ADDR_W + 1)'(1);
                    if (ptr == PTR_LAST) begin
                        state      <= DONE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight),
        .push_data  (mem_rdata),
        .pop        (rsp_pop),
        .head_valid (rsp_valid),
        .head_data  (rsp_rdata),
        .count      (rsp_count)
    );

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Testbench for mem_req_ctrl with a 16-word RAM (ADDR_W=4).
// dut  : CLEAR_ON_RESET=1, connected to a behavioural 1-cycle RAM.
// dut0 : CLEAR_ON_RESET=0, used for the reset-during-sweep sequence.
module tb_mem_req_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int NVEC  = 21;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          clear_start;
    logic          clear_busy;
    logic          clear_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    logic          rst0;
    logic          clear_start0;
    logic          clear_busy0;
    logic          clear_done0;
    logic [AW-1:0] mem_addr0;
    logic [DW-1:0] mem_wdata0;
    logic          mem_we0;
    wire  [DW-1:0] mem_rdata0 = '0;

    mem_req_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_req_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();

    mem_req_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .RSP_DEPTH(2),
        .CLEAR_VALUE(32'h0), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    mem_req_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .RSP_DEPTH(2),
        .CLEAR_VALUE(32'h0), .CLEAR_ON_RESET(1'b0)
    ) dut0 (
        .clk(clk), .rst(rst0), .bus(bus0.slave),
        .clear_start(clear_start0), .clear_busy(clear_busy0), .clear_done(clear_done0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_we(mem_we0), .mem_rdata(mem_rdata0)
    );

    // Behavioural RAM: registered read (read-before-write), 1-cycle latency.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic          valid;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          rsp_ready;
        logic          e_ready;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_rv;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t vecs [NVEC];
    int   checks_total  = 0;
    int   checks_passed = 0;

    function automatic vec_t mk(logic v, logic we, logic [AW-1:0] a, logic [DW-1:0] d, logic rr,
                                logic e_rdy, logic e_we, logic [AW-1:0] e_a, logic [DW-1:0] e_d,
                                logic e_rv, logic [DW-1:0] e_rd);
        vec_t r;
        r.valid = v;      r.we = we;       r.addr = a;       r.wdata = d;   r.rsp_ready = rr;
        r.e_ready = e_rdy; r.e_we = e_we;  r.e_addr = e_a;   r.e_wdata = e_d;
        r.e_rv = e_rv;    r.e_rdata = e_rd;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        bus.req_valid = v.valid;
        bus.req_we    = v.we;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        bus.rsp_ready = v.rsp_ready;
        #1;
    endtask

    task automatic driveIdle();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        int busy_cycles;
        int bad;

        // Directed vectors: writes, pipelined reads, then credit stall.
        vecs[0]  = mk(1'b1, 1'b1, 4'h5, 32'hDEADBEEF, 1'b1,  1'b1, 1'b1, 4'h5, 32'hDEADBEEF, 1'b0, 32'h0);
        vecs[1]  = mk(1'b1, 1'b1, 4'h1, 32'h11111111, 1'b1,  1'b1, 1'b1, 4'h1, 32'h11111111, 1'b0, 32'h0);
        vecs[2]  = mk(1'b1, 1'b1, 4'h2, 32'h22222222, 1'b1,  1'b1, 1'b1, 4'h2, 32'h22222222, 1'b0, 32'h0);
        vecs[3]  = mk(1'b1, 1'b1, 4'h3, 32'h33333333, 1'b1,  1'b1, 1'b1, 4'h3, 32'h33333333, 1'b0, 32'h0);
        vecs[4]  = mk(1'b1, 1'b1, 4'h4, 32'h44444444, 1'b1,  1'b1, 1'b1, 4'h4, 32'h44444444, 1'b0, 32'h0);
        vecs[5]  = mk(1'b1, 1'b0, 4'h5, 32'h0,        1'b1,  1'b1, 1'b0, 4'h5, 32'h0,        1'b0, 32'h0);
        vecs[6]  = mk(1'b1, 1'b0, 4'h1, 32'h0,        1'b1,  1'b1, 1'b0, 4'h1, 32'h0,        1'b0, 32'h0);
        vecs[7]  = mk(1'b1, 1'b0, 4'h2, 32'h0,        1'b1,  1'b1, 1'b0, 4'h2, 32'h0,        1'b1, 32'hDEADBEEF);
        vecs[8]  = mk(1'b1, 1'b0, 4'h3, 32'h0,        1'b1,  1'b1, 1'b0, 4'h3, 32'h0,        1'b1, 32'h11111111);
        vecs[9]  = mk(1'b1, 1'b0, 4'h4, 32'h0,        1'b1,  1'b1, 1'b0, 4'h4, 32'h0,        1'b1, 32'h22222222);
        vecs[10] = mk(1'b0, 1'b0, 4'h0, 32'h0,        1'b1,  1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h33333333);
        vecs[11] = mk(1'b0, 1'b0, 4'h0, 32'h0,        1'b1,  1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h44444444);
        vecs[12] = mk(1'b0, 1'b0, 4'h0, 32'h0,        1'b0,  1'b1, 1'b0, 4'h0, 32'h0,        1'b0, 32'h0);
        vecs[13] = mk(1'b1, 1'b0, 4'h1, 32'h0,        1'b0,  1'b1, 1'b0, 4'h1, 32'h0,        1'b0, 32'h0);
        vecs[14] = mk(1'b1, 1'b0, 4'h2, 32'h0,        1'b0,  1'b1, 1'b0, 4'h2, 32'h0,        1'b0, 32'h0);
        vecs[15] = mk(1'b1, 1'b0, 4'h3, 32'h0,        1'b0,  1'b0, 1'b0, 4'h0, 32'h0,        1'b1, 32'h11111111);
        vecs[16] = mk(1'b1, 1'b1, 4'h7, 32'h77777777, 1'b0,  1'b1, 1'b1, 4'h7, 32'h77777777, 1'b1, 32'h11111111);
        vecs[17] = mk(1'b1, 1'b0, 4'h3, 32'h0,        1'b1,  1'b1, 1'b0, 4'h3, 32'h0,        1'b1, 32'h11111111);
        vecs[18] = mk(1'b0, 1'b0, 4'h0, 32'h0,        1'b1,  1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h22222222);
        vecs[19] = mk(1'b0, 1'b0, 4'h0, 32'h0,        1'b1,  1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h33333333);
        vecs[20] = mk(1'b0, 1'b0, 4'h0, 32'h0,        1'b1,  1'b1, 1'b0, 4'h0, 32'h0,        1'b0, 32'h0);

        rst           = 1'b1;
        rst0          = 1'b1;
        clear_start   = 1'b0;
        clear_start0  = 1'b0;
        driveIdle();
        bus.rsp_ready  = 1'b1;
        bus0.req_valid = 1'b0;
        bus0.req_we    = 1'b0;
        bus0.req_addr  = '0;
        bus0.req_wdata = '0;
        bus0.rsp_ready = 1'b1;

        // Reset values.
        repeat (3) @(negedge clk);
        checkOutput("rst.req_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("rst.rsp_valid", 32'(bus.rsp_valid), 32'h0);
        checkOutput("rst.rsp_rdata", bus.rsp_rdata, 32'h0);
        checkOutput("rst.clear_busy", 32'(clear_busy), 32'h0);
        checkOutput("rst.clear_done", 32'(clear_done), 32'h0);
        checkOutput("rst.mem_we", 32'(mem_we), 32'h0);
        checkOutput("rst.mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst.mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;

        // Automatic sweep after reset release.
        waited = 0;
        while (!clear_busy && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput($sformatf("sweep%0d.busy_we_ready_addr", i),
                        32'({clear_busy, mem_we, bus.req_ready, mem_addr}),
                        32'({1'b1, 1'b1, 1'b0, 4'(i)}));
            @(negedge clk);
        end
        checkOutput("sweep.done_pulse", 32'({clear_done, clear_busy, bus.req_ready}), 32'b100);
        @(negedge clk);
        checkOutput("sweep.after_done", 32'({clear_done, clear_busy, bus.req_ready}), 32'b001);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ram[i] !== 32'h0) bad++;
        end
        checkOutput("sweep.ram_words_not_cleared", 32'(bad), 32'h0);

        // Table of per-cycle vectors.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d.req_ready", i), 32'(bus.req_ready), 32'(vecs[i].e_ready));
            checkOutput($sformatf("v%0d.mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
            checkOutput($sformatf("v%0d.mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
            checkOutput($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            checkOutput($sformatf("v%0d.rsp_valid", i), 32'(bus.rsp_valid), 32'(vecs[i].e_rv));
            checkOutput($sformatf("v%0d.rsp_rdata", i), bus.rsp_rdata, vecs[i].e_rdata);
        end

        // clear_start together with a read: the read completes, then the sweep.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'h5;
        bus.rsp_ready = 1'b1;
        clear_start   = 1'b1;
        #1;
        checkOutput("cs.read_accepted", 32'({bus.req_ready, mem_we, mem_addr}), 32'({1'b1, 1'b0, 4'h5}));
        @(negedge clk);
        clear_start   = 1'b0;
        bus.req_valid = 1'b1;
        #1;
        checkOutput("cs.busy_ptr0", 32'({clear_busy, mem_we, bus.req_ready, mem_addr}), 32'({1'b1, 1'b1, 1'b0, 4'h0}));
        checkOutput("cs.rsp_not_yet", 32'(bus.rsp_valid), 32'h0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        clear_start   = 1'b1;
        #1;
        checkOutput("cs.inflight_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        checkOutput("cs.inflight_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
        checkOutput("cs.busy_ptr1", 32'({clear_busy, mem_addr}), 32'({1'b1, 4'h1}));
        busy_cycles = 2;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            clear_start = 1'b0;
            if (!clear_busy) break;
            busy_cycles++;
        end
        checkOutput("cs.sweep_length", 32'(busy_cycles), 32'd16);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'h5;
        #1;
        checkOutput("cs.done_blocks_req", 32'({clear_done, bus.req_ready}), 32'b10);
        @(negedge clk);
        #1;
        checkOutput("cs.idle_accepts", 32'({clear_done, bus.req_ready, mem_addr}), 32'({1'b0, 1'b1, 4'h5}));
        @(negedge clk);
        driveIdle();
        #1;
        checkOutput("cs.latency_not_early", 32'(bus.rsp_valid), 32'h0);
        @(negedge clk);
        #1;
        checkOutput("cs.cleared_valid", 32'(bus.rsp_valid), 32'h1);
        checkOutput("cs.cleared_rdata", bus.rsp_rdata, 32'h0);

        // dut0: no automatic sweep, reset in the middle of a manual sweep.
        @(negedge clk);
        rst0 = 1'b0;
        @(negedge clk);
        checkOutput("r0.no_boot_sweep", 32'({bus0.req_ready, clear_busy0}), 32'b10);
        clear_start0 = 1'b1;
        @(negedge clk);
        clear_start0 = 1'b0;
        checkOutput("r0.sweep_started", 32'({clear_busy0, mem_addr0}), 32'({1'b1, 4'h0}));
        waited = 0;
        while (mem_addr0 != 4'h7 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("r0.at_ptr7", 32'({clear_busy0, mem_we0, mem_addr0}), 32'({1'b1, 1'b1, 4'h7}));
        rst0 = 1'b1;
        @(negedge clk);
        checkOutput("r0.rst_outputs",
                    32'({bus0.req_ready, bus0.rsp_valid, clear_busy0, clear_done0, mem_we0, mem_addr0}),
                    32'h0);
        checkOutput("r0.rst_wdata", mem_wdata0, 32'h0);
        checkOutput("r0.rst_rdata", bus0.rsp_rdata, 32'h0);
        rst0 = 1'b0;
        @(negedge clk);
        checkOutput("r0.ready_after_rst", 32'({bus0.req_ready, clear_busy0}), 32'b10);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (clear_busy0 || clear_done0 || mem_we0) bad++;
        end
        checkOutput("r0.no_restart_cycles", 32'(bad), 32'h0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
